// File: rtl/vend_pkg.sv
// Shared vending-panel definitions: debounce channel state encoding, button indices
// and a priority-encode helper used by the front-panel debouncer.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM_P = 2'd1,
        HELD  = 2'd2,
        ARM_R = 2'd3
    } chan_state_t;

    localparam int BTN_COIN5        = 0;
    localparam int BTN_COIN10       = 1;
    localparam int BTN_SELECT       = 2;
    localparam int BTN_CANCEL       = 3;
    localparam int TICK_PERIOD_CLKS = 50000;

    // Lowest set bit wins; an all-zero vector maps to index 0.
    function automatic logic [3:0] lowest_set_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, four-state accept/reject FSM and stability counter.
// Emits the debounced level and registered 1-clk press/release pulses.
module debounce_channel
    import vend_pkg::*;
#(
    parameter int STABLE_TICKS = 10,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    chan_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: if (s) begin
                    if (STABLE_TICKS == 1) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        state_d = ARM_P;
                        cnt_d   = CNT_ONE;
                    end
                end
                ARM_P: begin
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD: if (!s) begin
                    if (STABLE_TICKS == 1) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        state_d = ARM_R;
                        cnt_d   = CNT_ONE;
                    end
                end
                ARM_R: begin
                    if (s) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Level is a pure decode of the state register: high while accepted-pressed.
    assign level         = (state_q == HELD) || (state_q == ARM_R);
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Front-panel debouncer: NUM_BTN independent channels plus a registered output stage
// with press_any and a lowest-index-first press encoder, all aligned to btn_press.
module button_debouncer
    import vend_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int STABLE_TICKS = 10,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               press_any,
    output logic [3:0]         press_idx
);

    logic [NUM_BTN-1:0] lvl_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] rel_w;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .tick          (tick),
            .raw           (btn_raw[i]),
            .level         (lvl_w[i]),
            .press_pulse   (press_w[i]),
            .release_pulse (rel_w[i])
        );
    end

    // One register stage for every output keeps level, pulses and encoder in step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            press_any   <= 1'b0;
            press_idx   <= '0;
        end else begin
            btn_level   <= lvl_w;
            btn_press   <= press_w;
            btn_release <= rel_w;
            press_any   <= |press_w;
            press_idx   <= lowest_set_idx(16'(press_w));
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: STABLE_TICKS=4 instance with a tick every 5 clks, plus a
// STABLE_TICKS=1 instance with tick tied high.
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_press, btn_release;
    logic       press_any;
    logic [3:0] press_idx;

    logic [3:0] raw_b;
    logic [3:0] level_b, press_b, release_b;
    logic       press_any_b;
    logic [3:0] press_idx_b;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    always #5 clk = ~clk;

    button_debouncer #(.NUM_BTN(4), .STABLE_TICKS(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .press_any   (press_any),
        .press_idx   (press_idx)
    );

    button_debouncer #(.NUM_BTN(4), .STABLE_TICKS(1), .SYNC_STAGES(2)) dut_fast (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (1'b1),
        .btn_raw     (raw_b),
        .btn_level   (level_b),
        .btn_press   (press_b),
        .btn_release (release_b),
        .press_any   (press_any_b),
        .press_idx   (press_idx_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: present tick for the coming edge (every 5th edge), step past it.
    task automatic clk1();
        tick = (n % 5 == 4);
        @(posedge clk);
        #1;
        n++;
    endtask

    // Move so the next edge is the one right after a tick-free boundary (n % 5 == 0).
    task automatic align();
        while (n % 5 != 0) clk1();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) clk1();
    endtask

    initial begin
        int pc;
        int rc;
        int lc;

        reset_n = 1'b0;
        tick    = 1'b0;
        btn_raw = '0;
        raw_b   = '0;
        #2;
        check("rst_async_level", 32'(btn_level), 0);
        idle(3);
        check("rst_press",   32'(btn_press), 0);
        check("rst_release", 32'(btn_release), 0);
        check("rst_any",     32'(press_any), 0);
        check("rst_idx",     32'(press_idx), 0);
        reset_n = 1'b1;
        idle(5);

        // 1. Clean press on ch0: 2 sync clks, ticks at +4,+9,+14,+19, register at +20.
        align();
        btn_raw[0] = 1'b1;
        pc = 0;
        for (int i = 1; i <= 40; i++) begin
            clk1();
            if (btn_press[0]) pc++;
            if (i == 20) begin
                check("t1_pre_press", 32'(btn_press), 0);
                check("t1_pre_level", 32'(btn_level[0]), 0);
            end
            if (i == 21) begin
                check("t1_press", 32'(btn_press), 1);
                check("t1_level", 32'(btn_level[0]), 1);
                check("t1_any",   32'(press_any), 1);
                check("t1_idx",   32'(press_idx), 0);
            end
            if (i == 22) check("t1_post_press", 32'(btn_press), 0);
        end
        check("t1_press_count", 32'(pc), 1);

        // 2. Bounce on ch1, flipping every tick for 20 ticks: never accepted.
        align();
        pc = 0;
        lc = 0;
        for (int k = 0; k < 20; k++) begin
            btn_raw[1] = (k % 2 == 0);
            for (int j = 0; j < 5; j++) begin
                clk1();
                if (btn_press[1]) pc++;
                if (btn_level[1]) lc++;
            end
        end
        btn_raw[1] = 1'b0;
        idle(10);
        check("t2_press_count", 32'(pc), 0);
        check("t2_level_count", 32'(lc), 0);

        // 3. Press ch2, then release it.
        align();
        btn_raw[2] = 1'b1;
        idle(25);
        check("t3_held_level", 32'(btn_level[2]), 1);
        align();
        btn_raw[2] = 1'b0;
        pc = 0;
        rc = 0;
        for (int i = 1; i <= 40; i++) begin
            clk1();
            if (btn_press != 4'b0) pc++;
            if (btn_release[2]) rc++;
            if (i == 20) check("t3_pre_level", 32'(btn_level[2]), 1);
            if (i == 21) begin
                check("t3_release", 32'(btn_release), 4);
                check("t3_level",   32'(btn_level[2]), 0);
            end
        end
        check("t3_release_count", 32'(rc), 1);
        check("t3_no_press",      32'(pc), 0);

        // 4. Simultaneous press of ch1 and ch3.
        btn_raw = 4'b0000;
        idle(40);
        check("t4_idle_level", 32'(btn_level), 0);
        align();
        btn_raw = 4'b1010;
        for (int i = 1; i <= 30; i++) begin
            clk1();
            if (i == 20) check("t4_pre_press", 32'(btn_press), 0);
            if (i == 21) begin
                check("t4_press", 32'(btn_press), 10);
                check("t4_any",   32'(press_any), 1);
                check("t4_idx",   32'(press_idx), 1);
            end
            if (i == 22) begin
                check("t4_post_press", 32'(btn_press), 0);
                check("t4_post_any",   32'(press_any), 0);
            end
        end

        // 5. Reset while ch3 is mid-count, ch1 still held.
        btn_raw = 4'b0010;
        idle(40);
        check("t5_before_level", 32'(btn_level), 2);
        align();
        btn_raw[3] = 1'b1;
        idle(10);
        reset_n = 1'b0;
        #1;
        check("t5_rst_level", 32'(btn_level), 0);
        pc = 0;
        for (int i = 0; i < 3; i++) begin
            clk1();
            if (btn_press != 4'b0) pc++;
        end
        align();
        check("t5_rst_no_press", 32'(pc), 0);
        check("t5_rst_idx",      32'(press_idx), 0);
        reset_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            clk1();
            if (i == 20) check("t5_pre_press", 32'(btn_press), 0);
            if (i == 21) begin
                check("t5_fresh_press", 32'(btn_press), 10);
                check("t5_fresh_idx",   32'(press_idx), 1);
            end
        end

        // 6. Fast instance: tick always high, STABLE_TICKS=1.
        btn_raw = 4'b0000;
        idle(3);
        raw_b[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            clk1();
            if (i == 3) check("t6_pre_press", 32'(press_b), 0);
            if (i == 4) begin
                check("t6_press", 32'(press_b), 1);
                check("t6_level", 32'(level_b[0]), 1);
                check("t6_any",   32'(press_any_b), 1);
            end
            if (i == 5) check("t6_post_press", 32'(press_b), 0);
        end
        raw_b[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            clk1();
            if (i == 4) begin
                check("t6_release", 32'(release_b), 1);
                check("t6_rel_level", 32'(level_b[0]), 0);
            end
        end
        raw_b = 4'b1100;
        for (int i = 1; i <= 5; i++) begin
            clk1();
            if (i == 4) begin
                check("t6_multi_press", 32'(press_b), 12);
                check("t6_multi_idx",   32'(press_idx_b), 2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
